pipe_stage_elastic: RTL
=======================

# pipe_stage_elastic

Parametrised elastic pipeline-stage register for the pipelined OTTER core. It replaces fixed per-stage register banks such as decode-to-execute with one block that carries a generic control/data payload. It adds valid/ready flow control, a skid slot so back-pressure is not a combinational path, flush-to-bubble behaviour, and a saturating stall counter. One instance sits between each pair of adjacent stages.

## Interface
- CTRL_W, 16: width of control payload (RegWrite, MemWrite, Jump, Branch, ...); forced to zero whenever the output is a bubble
- DATA_W, 128: width of datapath payload (operands, PC, immediate, ...); never cleared except by reset
- SKID, 1: 1 = two-entry skid buffer with registered IN_READY; 0 = single entry with IN_READY = !main_valid | OUT_READY
- CNT_W, 16: stall counter width
- CLK  in  1  rising-edge clock; the only clock
- RST_N  in  1  asynchronous, active-low reset
- FLUSH  in  1  synchronous squash of all held entries
- IN_VALID  in  1  upstream offers a payload
- IN_READY  out  1  block accepts this cycle
- IN_CTRL  in  CTRL_W  upstream control payload
- IN_DATA  in  DATA_W  upstream data payload
- OUT_VALID  out  1  main entry valid
- OUT_READY  in  1  downstream accepts this cycle
- OUT_CTRL  out  CTRL_W  main control payload; 0 when OUT_VALID=0
- OUT_DATA  out  DATA_W  main data payload; holds last value when invalid
- STALL_CNT  out  CNT_W  saturating count of cycles with IN_VALID & !IN_READY

## Operation
- Transfer definitions:
  - Input transfer: IN_VALID & IN_READY.
  - Output transfer: OUT_VALID & OUT_READY.
- Storage: main entry (ctrl, data, valid) and, when SKID=1, a skid entry (ctrl, data, valid).
- States (SKID=1), derived from {skid_valid, main_valid}:
  - EMPTY (0,0), IN_READY=1:
    - input transfer -> FULL, with payload to main.
  - FULL (0,1), IN_READY=1:
    - in & out -> FULL, with new payload to main.
    - in & !out -> SKIDDED, with new payload to skid and main held.
    - !in & out -> EMPTY.
    - neither -> hold.
  - SKIDDED (1,1), IN_READY=0:
    - out -> FULL, with skid moved to main and skid cleared.
    - otherwise hold.
  - State (1,0) is illegal and never reachable.
- SKID=0: a single main entry.
  - Input transfer loads main.
  - Output transfer without input transfer clears main_valid.
- FLUSH=1 at an edge:
  - Next state is EMPTY; all valids are 0.
  - An input transfer in the same cycle is discarded.
  - An output transfer in the same cycle is still considered consumed by downstream.
  - FLUSH has priority over every other transition.
  - FLUSH does not change data registers or STALL_CNT.
- OUT_CTRL = main_ctrl & {CTRL_W{main_valid}}, so bubbles never assert RegWrite or MemWrite.
- STALL_CNT:
  - +1 on every edge where IN_VALID & !IN_READY.
  - Saturates at 2^CNT_W-1.
  - Cleared only by RST_N.

## Timing
- Reset (RST_N=0, asynchronous): OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, skid entry cleared, STALL_CNT=0, IN_READY=1. Deassertion is taken synchronously by the surrounding reset synchroniser.
- Latency: payload accepted at edge N appears on OUT_* after edge N (1 cycle). A skidded payload appears the cycle after the main entry drains.
- Throughput: 1 transfer/cycle sustained while OUT_READY=1.
- SKID=1:
  - IN_READY is a pure register output (= !skid_valid), with no comb path from OUT_READY.
  - OUT_* are register outputs apart from the AND masking.
- SKID=0: IN_READY depends combinationally on OUT_READY; intended only for stages with no back-pressure fan-in.
- Simultaneous FLUSH and RST_N: reset dominates.
- Inputs sampled only at the rising CLK edge; IN_* need not be stable while IN_READY=0.

## Test plan
- Reset mid-stream: SKID=1, two entries held, assert RST_N=0 between edges -> immediately OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, IN_READY=1, STALL_CNT=0.
- Streaming: OUT_READY=1, IN_VALID=1, DATA sequence 1,2,3,4 on consecutive cycles -> OUT_DATA 1,2,3,4 one cycle later, OUT_VALID continuously 1, STALL_CNT=0.
- Back-pressure: load A, OUT_READY=0, offer B then C -> B lands in skid, IN_READY=0 next cycle, C held upstream, STALL_CNT increments each stalled cycle. OUT_READY=1 -> outputs A, B, C in order with no loss or duplication.
- Flush with bubble: SKIDDED with IN_CTRL=16'hFFFF entries, FLUSH=1 together with IN_VALID=1 -> next cycle OUT_VALID=0, OUT_CTRL=16'h0000, IN_READY=1, and the flushed-cycle input never appears.
- Counter saturation: CNT_W=4, hold IN_VALID=1, OUT_READY=0 for 20 cycles -> STALL_CNT reaches 15 and stays 15. A following FLUSH leaves it at 15.
- SKID=0 variant: OUT_READY=0 with main valid -> IN_READY=0 in the same cycle. Toggle OUT_READY=1 -> IN_READY=1 combinationally and new data loads at that edge.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline-stage register with skid slot, flush-to-bubble and stall counter
module pipe_stage_elastic #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_xfer;
    logic              out_xfer;

    // With a skid slot, ready is purely registered; without one it looks through to out_ready.
    assign in_ready  = (SKID != 0) ? !skid_valid : (!main_valid || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_valid && out_ready;

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
    assign out_data  = main_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (SKID != 0) begin
            if (skid_valid) begin
                if (out_ready) begin
                    main_ctrl  <= skid_ctrl;
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end
            end else if (in_xfer && (!main_valid || out_ready)) begin
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else if (in_xfer) begin
                // Main is stuck behind back-pressure: park the newer payload in the skid slot.
                skid_ctrl  <= in_ctrl;
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
            end
        end else begin
            if (in_xfer) begin
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
